// File: rtl/vga_capture_pkg.sv
// Shared definitions for the video capture path: FSM encoding, default geometry, colour packing.
package vga_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  // Default geometry, shared with the display timing generator.
  localparam int DEF_WIDTH       = 1280;
  localparam int DEF_HEIGHT      = 720;
  localparam int DEF_CLIP_HEIGHT = 512;
  localparam int DEF_LINE_BITS   = 11;

  localparam int CLR_BITS  = 3;
  localparam int CLR_R_BIT = 2;
  localparam int CLR_G_BIT = 1;
  localparam int CLR_B_BIT = 0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Input register for one video pin plus rise/fall pulses of the registered value.
// Latency: level 1 clk after the pin, edge pulses valid in that same cycle; no backpressure.
module vga_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s0_q, s0_d;
  logic prev_q, prev_d;

  always_comb begin
    s0_d   = pin;
    prev_d = s0_q;
  end

  // Resetting both stages to the idle level avoids a phantom edge right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s0_q   <= s0_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = s0_q;
  assign rise = s0_q & ~prev_q;
  assign fall = ~s0_q & prev_q;

endmodule

// File: rtl/vga_capture.sv
// Video-input capture into a frame-buffer write port; pin to wr_* is 2 clk, one pixel per clk, no backpressure.
// Optional timing measurement built when VGA_CAPTURE_MEASURE_EN is defined; otherwise meas_* read 0.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int BPP         = 8,
  parameter int BPC         = 8,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int CLIP_HEIGHT = DEF_CLIP_HEIGHT,
  parameter int ADDR_BITS   = 20,
  parameter int LINE_BITS   = DEF_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_en,
  input  logic                 in_hs,
  input  logic                 in_vs,
  input  logic                 in_de,
  input  logic [BPC-1:0]       in_r,
  input  logic [BPC-1:0]       in_g,
  input  logic [BPC-1:0]       in_b,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [BPP-1:0]       wr_data,
  output logic                 frame_done,
  output logic                 locked,
  output logic [15:0]          frame_count,
  output logic [15:0]          meas_h_total,
  output logic [15:0]          meas_v_total
);

  localparam logic [LINE_BITS-1:0] W_L    = LINE_BITS'(WIDTH);
  localparam logic [LINE_BITS-1:0] H_L    = LINE_BITS'(HEIGHT);
  localparam logic [LINE_BITS-1:0] CLIP_L = LINE_BITS'(CLIP_HEIGHT);
  localparam logic [LINE_BITS-1:0] Y_MAX  = '1;
  localparam logic [ADDR_BITS-1:0] W_A    = ADDR_BITS'(WIDTH);

  logic vs_lvl, vs_rise, vs_fall;
  logic de_lvl, de_rise, de_fall;
  logic hs_lvl, hs_rise, hs_fall;

  vga_edge_detect #(.RST_VAL(1'b1)) u_vs (
    .clk(clk), .reset(reset), .pin(in_vs), .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall)
  );
  vga_edge_detect #(.RST_VAL(1'b0)) u_de (
    .clk(clk), .reset(reset), .pin(in_de), .lvl(de_lvl), .rise(de_rise), .fall(de_fall)
  );
  vga_edge_detect #(.RST_VAL(1'b1)) u_hs (
    .clk(clk), .reset(reset), .pin(in_hs), .lvl(hs_lvl), .rise(hs_rise), .fall(hs_fall)
  );

  logic [CLR_BITS-1:0] clr_q, clr_d;

  always_comb begin
    clr_d            = '0;
    clr_d[CLR_R_BIT] = in_r[BPC-1];
    clr_d[CLR_G_BIT] = in_g[BPC-1];
    clr_d[CLR_B_BIT] = in_b[BPC-1];
  end

  cap_state_e state_q, state_d;
  logic       st_wait, st_active;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture_en) state_d = ST_WAIT;
      ST_WAIT:   if (vs_rise) state_d = ST_ACTIVE;
      ST_ACTIVE: if (vs_rise && !capture_en) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    st_wait   = (state_q == ST_WAIT);
    st_active = (state_q == ST_ACTIVE);
  end

  logic [LINE_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic                 line_ok_q, line_ok_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [BPP-1:0]       wr_data_q, wr_data_d;
  logic [BPP-1:0]       pix_dat;
  logic                 frame_done_q, frame_done_d;
  logic                 locked_q, locked_d;
  logic [15:0]          fcount_q, fcount_d;

  always_comb begin
    pix_dat                 = '0;
    pix_dat[CLR_BITS-1:0]   = clr_q;
  end

  // Line end is folded in before the frame boundary so a coincident DE fall still counts.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    line_ok_d    = line_ok_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    locked_d     = locked_q;
    fcount_d     = fcount_q;

    if (st_wait && vs_rise) begin
      x_d       = '0;
      y_d       = '0;
      base_d    = '0;
      line_ok_d = 1'b1;
    end

    if (st_active) begin
      if (de_lvl) begin
        if (y_q < CLIP_L && x_q < W_L) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_BITS'(x_q);
          wr_data_d = pix_dat;
        end
        if (x_q != W_L) x_d = x_q + 1'b1;
      end
      if (de_fall) begin
        line_ok_d = line_ok_q && (x_q == W_L);
        if (y_q != Y_MAX) begin
          y_d    = y_q + 1'b1;
          base_d = base_q + W_A;
        end
        x_d = '0;
      end
      if (vs_rise) begin
        frame_done_d = 1'b1;
        locked_d     = line_ok_d && (y_d == H_L);
        fcount_d     = fcount_q + 16'd1;
        x_d          = '0;
        y_d          = '0;
        base_d       = '0;
        line_ok_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      line_ok_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      fcount_q     <= '0;
    end else begin
      clr_q        <= clr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      line_ok_q    <= line_ok_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      fcount_q     <= fcount_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign frame_count = fcount_q;

`ifdef VGA_CAPTURE_MEASURE_EN
  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;

  always_comb begin
    h_cnt_d  = sat_inc16(h_cnt_q);
    v_cnt_d  = v_cnt_q;
    meas_h_d = meas_h_q;
    meas_v_d = meas_v_q;
    if (de_rise) begin
      meas_h_d = h_cnt_q;
      h_cnt_d  = 16'd1;
    end
    if (hs_fall) v_cnt_d = sat_inc16(v_cnt_q);
    if (vs_rise) begin
      meas_v_d = v_cnt_d;
      v_cnt_d  = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      meas_h_q <= '0;
      meas_v_q <= '0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      meas_h_q <= meas_h_d;
      meas_v_q <= meas_v_d;
    end
  end

  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;
`else
  logic unused_meas;
  assign unused_meas  = hs_fall ^ de_rise;
  assign meas_h_total = '0;
  assign meas_v_total = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{in_r[BPC-2:0], in_g[BPC-2:0], in_b[BPC-2:0],
                         vs_lvl, vs_fall, hs_lvl, hs_rise};

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled 24x16 / 16x12 stream with an 8-line clip.
module tb_vga_capture;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int CLIP = 8;
  localparam int HT   = 24;
  localparam int VT   = 16;
`ifdef VGA_CAPTURE_MEASURE_EN
  localparam int EXP_H = HT;
  localparam int EXP_V = VT;
`else
  localparam int EXP_H = 0;
  localparam int EXP_V = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic        in_hs = 1'b1;
  logic        in_vs = 1'b1;
  logic        in_de = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done, locked;
  logic [15:0] frame_count, meas_h_total, meas_v_total;

  always #5 clk = ~clk;

  vga_capture #(
    .BPP(8), .BPC(8), .WIDTH(W), .HEIGHT(H), .CLIP_HEIGHT(CLIP), .ADDR_BITS(20), .LINE_BITS(11)
  ) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked), .frame_count(frame_count),
    .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stream source: line = 16 DE + 2 fp + 2 HS + 4 bp; frame = 1 bp line, 12 active, 1 fp, 2 VS.
  int hc = 0, vc = 5, gen_frame = 0, gen_x = -1, gen_y = -1, short_y = -1;

  initial begin : gen
    int y;
    logic de;
    logic [7:0] rr, gg, bb;
    forever begin
      @(negedge clk);
      y  = vc - 1;
      de = (vc >= 1 && vc <= H) && (hc < ((y == short_y) ? W - 1 : W));
      in_de = de;
      in_hs = !(hc >= 18 && hc < 20);
      in_vs = !(vc >= 14);
      gen_x = de ? hc : -1;
      gen_y = de ? y : -1;
      rr = 8'h55; gg = 8'h2A; bb = 8'h11;
      rr[7] = hc[0];
      gg[7] = y[0];
      bb[7] = hc[1];
      if (de && hc == 5 && y == 3) begin
        rr = 8'h80; gg = 8'h00; bb = 8'hFF;
      end
      in_r = rr; in_g = gg; in_b = bb;
      if (vc == 0 && hc == 0) gen_frame++;
      hc++;
      if (hc == HT) begin
        hc = 0;
        vc = (vc + 1) % VT;
      end
    end
  end

  int wr_total = 0, done_total = 0;
  logic [19:0] last_addr = '0;

  initial begin : mon
    int ax, ay;
    logic [7:0] ed;
    forever begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) done_total++;
      if (wr_en === 1'b1) begin
        wr_total++;
        last_addr = wr_addr;
        ax = int'(wr_addr) % W;
        ay = int'(wr_addr) / W;
        ed = '0;
        if (ax == 5 && ay == 3) ed = 8'h05;
        else begin
          ed[2] = ax[0];
          ed[1] = ay[0];
          ed[0] = ax[1];
        end
        check("wr_addr_range", 32'(wr_addr < 20'(W * CLIP)), 32'd1);
        check("wr_data", 32'(wr_data), 32'(ed));
      end
    end
  end

  task automatic wait_frames(input int n);
    int target, cyc;
    target = gen_frame + n;
    cyc = 0;
    while (gen_frame < target && cyc < n * HT * VT * 2) begin
      @(posedge clk);
      cyc++;
    end
    if (gen_frame < target) begin
      checks++;
      fails++;
      $display("FAIL frame_wait: reached %0d boundaries, expected %0d", gen_frame, target);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_pixel(input int px, input int py);
    bit found;
    found = 0;
    for (int c = 0; c < HT * VT * 2 && !found; c++) begin
      @(posedge clk);
      if (gen_x == px && gen_y == py) found = 1;
    end
    if (!found) begin
      checks++;
      fails++;
      $display("FAIL pixel_wait: pixel (%0d,%0d) never driven", px, py);
    end
  endtask

  task automatic check_reset_values();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_meas_h", 32'(meas_h_total), 32'd0);
    check("rst_meas_v", 32'(meas_v_total), 32'd0);
  endtask

  typedef struct {
    bit cap;
    int short_y;
    int frames;
    int exp_done;
    int exp_writes;
    bit exp_locked;
    int exp_fcount;
  } row_t;

  row_t rows[7];
  int ws, ds;

  initial begin
    rows[0] = '{1'b1, -1, 2, 2, 2 * W * CLIP, 1'b1, 2};
    rows[1] = '{1'b1,  5, 1, 1, W * CLIP - 1, 1'b0, 3};
    rows[2] = '{1'b1, -1, 1, 1, W * CLIP,     1'b1, 4};
    rows[3] = '{1'b0, -1, 1, 1, W * CLIP,     1'b1, 5};
    rows[4] = '{1'b0, -1, 1, 0, 0,            1'b1, 5};
    rows[5] = '{1'b1, -1, 1, 0, 0,            1'b1, 5};
    rows[6] = '{1'b1, -1, 1, 1, W * CLIP,     1'b1, 6};

    repeat (4) @(posedge clk);
    #1;
    check_reset_values();

    // Arm mid-frame: DE activity before the first boundary must not be written.
    reset = 1'b0;
    capture_en = 1'b1;
    ws = wr_total;
    ds = done_total;
    wait_frames(1);
    check("pre_boundary_writes", 32'(wr_total - ws), 32'd0);
    check("pre_boundary_done", 32'(done_total - ds), 32'd0);

    for (int i = 0; i < 7; i++) begin
      capture_en = rows[i].cap;
      short_y    = rows[i].short_y;
      ws = wr_total;
      ds = done_total;
      wait_frames(rows[i].frames);
      check($sformatf("row%0d_frame_done", i), 32'(done_total - ds), 32'(rows[i].exp_done));
      check($sformatf("row%0d_writes", i), 32'(wr_total - ws), 32'(rows[i].exp_writes));
      check($sformatf("row%0d_locked", i), 32'(locked), 32'(rows[i].exp_locked));
      check($sformatf("row%0d_frame_count", i), 32'(frame_count), 32'(rows[i].exp_fcount));
      check($sformatf("row%0d_meas_h", i), 32'(meas_h_total), 32'(EXP_H));
      check($sformatf("row%0d_meas_v", i), 32'(meas_v_total), 32'(EXP_V));
      if (rows[i].exp_writes > 0)
        check($sformatf("row%0d_last_addr", i), 32'(last_addr), 32'(W * CLIP - 1));
    end
    short_y = -1;

    // Pixel (5,3) appears on the write port two clocks after the pins.
    wait_pixel(5, 3);
    @(posedge clk);
    #1;
    check("px53_wr_en", 32'(wr_en), 32'd1);
    check("px53_wr_addr", 32'(wr_addr), 32'(3 * W + 5));
    check("px53_wr_data", 32'(wr_data), 32'h05);

    // Reset in the middle of a line.
    wait_pixel(6, 4);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    ws = wr_total;
    ds = done_total;
    wait_frames(1);
    check("post_reset_writes", 32'(wr_total - ws), 32'd0);
    check("post_reset_done", 32'(done_total - ds), 32'd0);
    ws = wr_total;
    ds = done_total;
    wait_frames(1);
    check("rearm_writes", 32'(wr_total - ws), 32'(W * CLIP));
    check("rearm_done", 32'(done_total - ds), 32'd1);
    check("rearm_locked", 32'(locked), 32'd1);
    check("rearm_frame_count", 32'(frame_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
